// File: rtl/vga_event_gen.sv
// Turns effect switches and level inputs into one-at-a-time plotter events with a busy handshake.
// Define EVENT_GEN_DEBOUNCE_EN to debounce each synchronised switch before edge detection.
module vga_event_gen #(
  parameter int unsigned REFRESH_CYCLES  = 833333,
  parameter int unsigned ACK_TIMEOUT     = 15
`ifdef EVENT_GEN_DEBOUNCE_EN
  , parameter int unsigned DEBOUNCE_CYCLES = 500000
`endif
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [2:0] effect_sw_i,
  input  logic [6:0] volume_level_i,
  input  logic [6:0] pitch_level_i,
  input  logic [6:0] distortion_level_i,
  input  logic       plot_busy_i,
  output logic       VolumeTurnedOn_o,
  output logic       PitchTurnedOn_o,
  output logic       DistortionTurnedOn_o,
  output logic       VolumeTurnedOff_o,
  output logic       PitchTurnedOff_o,
  output logic       DistortionTurnedOff_o,
  output logic       VolumeGo_o,
  output logic       PitchGo_o,
  output logic       DistortionGo_o,
  output logic       EffectGo_o,
  output logic [6:0] volume_data_o,
  output logic [6:0] pitch_data_o,
  output logic [6:0] distortion_data_o
);
  localparam int unsigned REF_W   = $clog2(REFRESH_CYCLES + 1);
  localparam int unsigned ACK_W   = $clog2(ACK_TIMEOUT + 1);
  localparam logic [6:0]  LVL_MAX = 7'd99;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE} state_e;

  function automatic logic [6:0] clamp(input logic [6:0] v);
    return (v > LVL_MAX) ? LVL_MAX : v;
  endfunction

  logic [2:0]       sync1_q, sync2_q, sw_prev_q, sw_cur;
  logic [2:0]       rise, fall;
  logic [2:0]       on_q, off_q, upd_q;
  logic [2:0][6:0]  lvl_c, last_q, data_q;
  logic [REF_W-1:0] ref_q;
  logic             tick;
  logic [8:0]       pend_c, sel_oh_c, take_c, ev_q;
  logic [ACK_W-1:0] ack_cnt_q;
  state_e           state_q;
  logic [2:0]       on_pls_q, off_pls_q, go_q;
  logic             effect_go_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      sw_prev_q <= '0;
    end else begin
      sync1_q   <= effect_sw_i;
      sync2_q   <= sync1_q;
      sw_prev_q <= sw_cur;
    end
  end

`ifdef EVENT_GEN_DEBOUNCE_EN
  localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
  logic [2:0]            deb_q;
  logic [2:0][DEB_W-1:0] deb_cnt_q;

  // Debounced bit follows the synced input only after a full run of differing cycles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      deb_q     <= '0;
      deb_cnt_q <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
          deb_q[i]     <= sync2_q[i];
          deb_cnt_q[i] <= '0;
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + DEB_W'(1);
        end
      end
    end
  end
  assign sw_cur = deb_q;
`else
  assign sw_cur = sync2_q;
`endif

  assign rise  = sw_cur & ~sw_prev_q;
  assign fall  = ~sw_cur & sw_prev_q;
  assign lvl_c = {clamp(distortion_level_i), clamp(pitch_level_i), clamp(volume_level_i)};
  assign tick  = (ref_q == REF_W'(REFRESH_CYCLES - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ref_q <= '0;
    else       ref_q <= tick ? '0 : ref_q + REF_W'(1);
  end

  // Priority order, lowest index wins: vol on/off, pitch on/off, dist on/off, then updates.
  assign pend_c   = {upd_q, off_q[2], on_q[2], off_q[1], on_q[1], off_q[0], on_q[0]};
  assign sel_oh_c = pend_c & (~pend_c + 9'd1);
  assign take_c   = (state_q == S_IDLE && !plot_busy_i) ? sel_oh_c : '0;

  // Latest edge wins over the opposite flag; a served update is cleared even on a coincident tick.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      on_q  <= '0;
      off_q <= '0;
      upd_q <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        on_q[i]  <= (on_q[i] & ~take_c[2*i] & ~fall[i]) | rise[i];
        off_q[i] <= (off_q[i] & ~take_c[2*i+1] & ~rise[i]) | fall[i];
        upd_q[i] <= (upd_q[i] | (tick & sw_cur[i] & (lvl_c[i] != last_q[i]))) & ~take_c[6+i];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      ev_q        <= '0;
      ack_cnt_q   <= '0;
      data_q      <= '0;
      last_q      <= '0;
      on_pls_q    <= '0;
      off_pls_q   <= '0;
      go_q        <= '0;
      effect_go_q <= 1'b0;
    end else begin
      on_pls_q    <= '0;
      off_pls_q   <= '0;
      go_q        <= '0;
      effect_go_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (|take_c) begin
            ev_q   <= take_c;
            data_q <= lvl_c;
            for (int i = 0; i < 3; i++) begin
              if (take_c[6+i]) last_q[i] <= lvl_c[i];
            end
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          on_pls_q    <= {ev_q[4], ev_q[2], ev_q[0]};
          off_pls_q   <= {ev_q[5], ev_q[3], ev_q[1]};
          go_q        <= ev_q[8:6];
          effect_go_q <= |ev_q[8:6];
          ack_cnt_q   <= '0;
          state_q     <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (plot_busy_i) begin
            state_q <= S_WAIT_DONE;
          end else if (ack_cnt_q == ACK_W'(ACK_TIMEOUT - 1)) begin
            state_q <= S_IDLE;
          end else begin
            ack_cnt_q <= ack_cnt_q + ACK_W'(1);
          end
        end
        S_WAIT_DONE: begin
          if (!plot_busy_i) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign VolumeTurnedOn_o      = on_pls_q[0];
  assign PitchTurnedOn_o       = on_pls_q[1];
  assign DistortionTurnedOn_o  = on_pls_q[2];
  assign VolumeTurnedOff_o     = off_pls_q[0];
  assign PitchTurnedOff_o      = off_pls_q[1];
  assign DistortionTurnedOff_o = off_pls_q[2];
  assign VolumeGo_o            = go_q[0];
  assign PitchGo_o             = go_q[1];
  assign DistortionGo_o        = go_q[2];
  assign EffectGo_o            = effect_go_q;
  assign volume_data_o         = data_q[0];
  assign pitch_data_o          = data_q[1];
  assign distortion_data_o     = data_q[2];
endmodule
